// File: rtl/multicycle_processor_if.sv
// Unified memory port between the multicycle core and its memory.
// The core is the master; wait states come from mem_ready.
interface multicycle_processor_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_wdata;
    logic [31:0]           mem_rdata;
    logic                  mem_ready;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/multicycle_processor.sv
// Multicycle MIPS-subset core: one ALU, one register file, one memory port.
// An FSM sequences fetch/decode/execute; traps park the core in HALT.
module multicycle_processor #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          ADDR_WIDTH  = 32,
    parameter bit          CHECK_ALIGN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    multicycle_processor_if.master bus,
    output logic        retired,
    output logic        halted,
    output logic        illegal_op,
    output logic        misaligned,
    output logic [31:0] dbg_pc
);

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC,
        ALUWB, ADDIEX, ADDIWB, BRANCH, JUMP, HALT
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT
    } alu_t;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_J    = 6'h02;

    localparam logic [5:0] F_ADD = 6'h20;
    localparam logic [5:0] F_SUB = 6'h22;
    localparam logic [5:0] F_AND = 6'h24;
    localparam logic [5:0] F_OR  = 6'h25;
    localparam logic [5:0] F_SLT = 6'h2A;

    state_t      state, next;
    logic [31:0] pc, ir, a, b, alu_out, mdr;
    logic [31:0] rf [32];

    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd;
    logic [31:0] sext;
    logic        is_r, is_mem, is_beq, is_addi, is_j, dec_illegal;

    alu_t        alu_ctl;
    logic [31:0] alu_a, alu_b, alu_y;
    logic        align_bad;

    logic        req, we, ret;
    logic [31:0] addr_full;

    assign op    = ir[31:26];
    assign rs    = ir[25:21];
    assign rt    = ir[20:16];
    assign rd    = ir[15:11];
    assign funct = ir[5:0];
    assign sext  = {{16{ir[15]}}, ir[15:0]};

    assign is_r = (op == OP_R) &&
                  (funct == F_ADD || funct == F_SUB ||
                   funct == F_AND || funct == F_OR ||
                   funct == F_SLT);
    assign is_mem  = (op == OP_LW) || (op == OP_SW);
    assign is_beq  = (op == OP_BEQ);
    assign is_addi = (op == OP_ADDI);
    assign is_j    = (op == OP_J);
    assign dec_illegal = !(is_r | is_mem | is_beq | is_addi | is_j);

    // Shared ALU: operand routing depends only on the current state.
    always_comb begin
        alu_a   = pc;
        alu_b   = 32'd4;
        alu_ctl = ALU_ADD;
        case (state)
            DECODE: alu_b = {sext[29:0], 2'b00};
            MEMADR, ADDIEX: begin
                alu_a = a;
                alu_b = sext;
            end
            EXEC: begin
                alu_a = a;
                alu_b = b;
                unique case (1'b1)
                    (funct == F_SUB): alu_ctl = ALU_SUB;
                    (funct == F_AND): alu_ctl = ALU_AND;
                    (funct == F_OR):  alu_ctl = ALU_OR;
                    (funct == F_SLT): alu_ctl = ALU_SLT;
                    default:          alu_ctl = ALU_ADD;
                endcase
            end
            default: ;
        endcase
    end

    always_comb begin
        alu_y = alu_a + alu_b;
        case (alu_ctl)
            ALU_SUB: alu_y = alu_a - alu_b;
            ALU_AND: alu_y = alu_a & alu_b;
            ALU_OR:  alu_y = alu_a | alu_b;
            ALU_SLT: alu_y = {31'b0, $signed(alu_a) < $signed(alu_b)};
            default: alu_y = alu_a + alu_b;
        endcase
    end

    assign align_bad = CHECK_ALIGN && (alu_y[1:0] != 2'b00);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= FETCH;
        else     state <= next;
    end

    always_comb begin
        next      = state;
        req       = 1'b0;
        we        = 1'b0;
        addr_full = pc;
        ret       = 1'b0;
        case (state)
            FETCH: begin
                req = 1'b1;
                if (bus.mem_ready) next = DECODE;
            end
            DECODE: begin
                if (dec_illegal) next = HALT;
                else begin
                    unique case (1'b1)
                        is_mem:  next = MEMADR;
                        is_r:    next = EXEC;
                        is_addi: next = ADDIEX;
                        is_beq:  next = BRANCH;
                        is_j:    next = JUMP;
                        default: next = HALT;
                    endcase
                end
            end
            MEMADR: begin
                if (align_bad)         next = HALT;
                else if (op == OP_LW)  next = MEMRD;
                else                   next = MEMWR;
            end
            MEMRD: begin
                req       = 1'b1;
                addr_full = alu_out;
                if (bus.mem_ready) next = MEMWB;
            end
            MEMWB: begin
                ret  = 1'b1;
                next = FETCH;
            end
            MEMWR: begin
                req       = 1'b1;
                we        = 1'b1;
                addr_full = alu_out;
                if (bus.mem_ready) begin
                    ret  = 1'b1;
                    next = FETCH;
                end
            end
            EXEC:   next = ALUWB;
            ADDIEX: next = ADDIWB;
            ALUWB, ADDIWB, BRANCH, JUMP: begin
                ret  = 1'b1;
                next = FETCH;
            end
            default: next = HALT;
        endcase
    end

    // Reset wins over the FETCH request so an abandoned access drops at once.
    assign bus.mem_req   = req && !rst;
    assign bus.mem_we    = we && !rst;
    assign bus.mem_addr  = addr_full[ADDR_WIDTH-1:0];
    assign bus.mem_wdata = b;
    assign retired       = ret && !rst;
    assign halted        = (state == HALT);
    assign dbg_pc        = pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc         <= RESET_PC;
            ir         <= '0;
            a          <= '0;
            b          <= '0;
            alu_out    <= '0;
            mdr        <= '0;
            illegal_op <= 1'b0;
            misaligned <= 1'b0;
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else begin
            case (state)
                FETCH: begin
                    if (bus.mem_ready) begin
                        ir <= bus.mem_rdata;
                        pc <= alu_y;
                    end
                end
                DECODE: begin
                    a       <= rf[rs];
                    b       <= rf[rt];
                    alu_out <= alu_y;
                    if (dec_illegal) illegal_op <= 1'b1;
                end
                MEMADR: begin
                    alu_out <= alu_y;
                    if (align_bad) misaligned <= 1'b1;
                end
                MEMRD: if (bus.mem_ready) mdr <= bus.mem_rdata;
                MEMWB: if (rt != 5'd0) rf[rt] <= mdr;
                EXEC, ADDIEX: alu_out <= alu_y;
                ALUWB:  if (rd != 5'd0) rf[rd] <= alu_out;
                ADDIWB: if (rt != 5'd0) rf[rt] <= alu_out;
                BRANCH: if (a == b) pc <= alu_out;
                JUMP:   pc <= {pc[31:28], ir[25:0], 2'b00};
                default: ;
            endcase
        end
    end

endmodule
